// File: rtl/csr_unit_if.sv
// Decoder/EX-stage bundle for csr_unit: CSR controls, trap indicators,
// old-value readback and the registered fetch redirect.
interface csr_unit_if;
  logic        valid;
  logic        CSRWrite;
  logic        CSRRead;
  logic [2:0]  CSROp;
  logic [11:0] csr_addr;
  logic [31:0] rs1_data;
  logic [4:0]  csr_zimm;
  logic        IsMRET;
  logic        Exception;
  logic [31:0] ExceptionCause;
  logic [31:0] pc;
  logic        inst_retire;
  logic [31:0] rdata;
  logic        illegal_csr;
  logic        trap_redirect;
  logic [31:0] trap_target;

  modport master (
    output valid, CSRWrite, CSRRead, CSROp, csr_addr, rs1_data, csr_zimm,
           IsMRET, Exception, ExceptionCause, pc, inst_retire,
    input  rdata, illegal_csr, trap_redirect, trap_target
  );

  modport slave (
    input  valid, CSRWrite, CSRRead, CSROp, csr_addr, rs1_data, csr_zimm,
           IsMRET, Exception, ExceptionCause, pc, inst_retire,
    output rdata, illegal_csr, trap_redirect, trap_target
  );
endinterface

// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap/return sequencer with a one-cycle PC redirect.
// Define CSR_COUNTERS_EN to add the 64-bit mcycle/minstret counters.
//
// state      | meaning
// S_IDLE     | executing CSR ops; ECALL/MRET capture trap state and redirect
// S_REDIRECT | one-cycle trap_redirect pulse; pipeline flushing, inputs ignored
module csr_unit #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input logic      clk,
  input logic      rstn,
  csr_unit_if.slave bus
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;

  typedef enum logic {S_IDLE, S_REDIRECT} state_t;

  state_t      state_q;
  logic        mie_q, mpie_q;
  logic [31:0] mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic        redirect_q;
  logic [31:0] target_q;

  logic [31:0] mstatus_rd;
  logic [31:0] csr_old;
  logic        csr_hit;
  logic        illegal;
  logic [31:0] operand;
  logic [31:0] csr_wdata;
  logic        trap_fire, mret_fire, csr_we;

`ifdef CSR_COUNTERS_EN
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;
`else
  logic unused_retire;
  assign unused_retire = bus.inst_retire;
`endif

  // MPP is hardwired to machine mode
  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};

  always_comb begin
    csr_hit = 1'b1;
    csr_old = '0;
    case (bus.csr_addr)
      ADDR_MSTATUS:   csr_old = mstatus_rd;
      ADDR_MTVEC:     csr_old = mtvec_q;
      ADDR_MSCRATCH:  csr_old = mscratch_q;
      ADDR_MEPC:      csr_old = mepc_q;
      ADDR_MCAUSE:    csr_old = mcause_q;
`ifdef CSR_COUNTERS_EN
      ADDR_MCYCLE:    csr_old = mcycle_q[31:0];
      ADDR_MCYCLEH:   csr_old = mcycle_q[63:32];
      ADDR_MINSTRET:  csr_old = minstret_q[31:0];
      ADDR_MINSTRETH: csr_old = minstret_q[63:32];
`endif
      default:        csr_hit = 1'b0;
    endcase
  end

  assign illegal = (bus.CSRRead | bus.CSRWrite) & ~csr_hit;
  assign operand = bus.CSROp[2] ? {27'b0, bus.csr_zimm} : bus.rs1_data;

  always_comb begin
    case (bus.CSROp[1:0])
      2'b01:   csr_wdata = operand;
      2'b10:   csr_wdata = csr_old | operand;
      2'b11:   csr_wdata = csr_old & ~operand;
      default: csr_wdata = csr_old;
    endcase
  end

  assign trap_fire = bus.valid & bus.Exception;
  assign mret_fire = bus.valid & bus.IsMRET;
  assign csr_we    = (state_q == S_IDLE) & bus.valid & bus.CSRWrite & ~illegal
                     & ~bus.Exception & ~bus.IsMRET;

`ifdef CSR_COUNTERS_EN
  // A software write to either half replaces that cycle's increment
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, bus.inst_retire};
    if (csr_we && bus.csr_addr == ADDR_MCYCLE)
      mcycle_d = {mcycle_q[63:32], csr_wdata};
    else if (csr_we && bus.csr_addr == ADDR_MCYCLEH)
      mcycle_d = {csr_wdata, mcycle_q[31:0]};
    if (csr_we && bus.csr_addr == ADDR_MINSTRET)
      minstret_d = {minstret_q[63:32], csr_wdata};
    else if (csr_we && bus.csr_addr == ADDR_MINSTRETH)
      minstret_d = {csr_wdata, minstret_q[31:0]};
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= RESET_MTVEC & ~32'h3;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      redirect_q <= 1'b0;
      target_q   <= '0;
`ifdef CSR_COUNTERS_EN
      mcycle_q   <= '0;
      minstret_q <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (trap_fire) begin
            mepc_q     <= bus.pc & ~32'h3;
            mcause_q   <= bus.ExceptionCause;
            mpie_q     <= mie_q;
            mie_q      <= 1'b0;
            target_q   <= mtvec_q;
            redirect_q <= 1'b1;
            state_q    <= S_REDIRECT;
          end else if (mret_fire) begin
            mie_q      <= mpie_q;
            mpie_q     <= 1'b1;
            target_q   <= mepc_q;
            redirect_q <= 1'b1;
            state_q    <= S_REDIRECT;
          end else if (csr_we) begin
            case (bus.csr_addr)
              ADDR_MSTATUS: begin
                mie_q  <= csr_wdata[3];
                mpie_q <= csr_wdata[7];
              end
              ADDR_MTVEC:    mtvec_q    <= csr_wdata & ~32'h3;
              ADDR_MSCRATCH: mscratch_q <= csr_wdata;
              ADDR_MEPC:     mepc_q     <= csr_wdata & ~32'h3;
              ADDR_MCAUSE:   mcause_q   <= csr_wdata;
              default: ;
            endcase
          end
        end
        S_REDIRECT: begin
          redirect_q <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: begin
          redirect_q <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
`ifdef CSR_COUNTERS_EN
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
`endif
    end
  end

  assign bus.rdata         = csr_old;
  assign bus.illegal_csr   = illegal;
  assign bus.trap_redirect = redirect_q;
  assign bus.trap_target   = target_q;

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: directed scenarios with literal expectations,
// then random traffic checked every cycle against a CSR-level model.
module tb_csr_unit;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;

  csr_unit_if bus();

  csr_unit dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;

  // model state
  bit          m_mie, m_mpie, m_redir;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_tgt;
  logic [63:0] m_cyc, m_inst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_redir = 0;
    m_mtvec = 32'h0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_tgt = 0;
    m_cyc = 0; m_inst = 0;
  endtask

  function automatic bit m_impl(input logic [11:0] a);
    case (a)
      12'h300, 12'h305, 12'h340, 12'h341, 12'h342: return 1'b1;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hB80, 12'hB02, 12'hB82: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
`ifdef CSR_COUNTERS_EN
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      12'hB02: return m_inst[31:0];
      12'hB82: return m_inst[63:32];
`endif
      default: return 32'h0;
    endcase
  endfunction

  // Compare outputs of this cycle, then advance the model across the coming edge.
  always @(negedge clk) begin
    logic [31:0] erd, opnd, nv;
    bit eil, wr_cyc, wr_inst;
    if (chk_en) begin
      if (!rstn) model_reset();
      eil = (bus.CSRRead || bus.CSRWrite) && !m_impl(bus.csr_addr);
      erd = m_read(bus.csr_addr);
      chk("rdata", bus.rdata, erd);
      chk("illegal_csr", 32'(bus.illegal_csr), 32'(eil));
      chk("trap_redirect", 32'(bus.trap_redirect), 32'(m_redir));
      if (m_redir) chk("trap_target", bus.trap_target, m_tgt);
      if (rstn) begin
        wr_cyc = 0; wr_inst = 0;
        if (m_redir) begin
          m_redir = 0;
        end else if (bus.valid && bus.Exception) begin
          m_mepc = bus.pc & ~32'h3; m_mcause = bus.ExceptionCause;
          m_mpie = m_mie; m_mie = 0; m_tgt = m_mtvec; m_redir = 1;
        end else if (bus.valid && bus.IsMRET) begin
          m_mie = m_mpie; m_mpie = 1; m_tgt = m_mepc; m_redir = 1;
        end else if (bus.valid && bus.CSRWrite && !eil) begin
          opnd = bus.CSROp[2] ? {27'b0, bus.csr_zimm} : bus.rs1_data;
          case (bus.CSROp)
            3'b001, 3'b101: nv = opnd;
            3'b010, 3'b110: nv = erd | opnd;
            3'b011, 3'b111: nv = erd & ~opnd;
            default:        nv = erd;
          endcase
          case (bus.csr_addr)
            12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
            12'h305: m_mtvec = nv & ~32'h3;
            12'h340: m_mscratch = nv;
            12'h341: m_mepc = nv & ~32'h3;
            12'h342: m_mcause = nv;
            12'hB00: begin m_cyc[31:0] = nv; wr_cyc = 1; end
            12'hB80: begin m_cyc[63:32] = nv; wr_cyc = 1; end
            12'hB02: begin m_inst[31:0] = nv; wr_inst = 1; end
            12'hB82: begin m_inst[63:32] = nv; wr_inst = 1; end
            default: ;
          endcase
        end
        if (!wr_cyc) m_cyc = m_cyc + 64'd1;
        if (!wr_inst && bus.inst_retire) m_inst = m_inst + 64'd1;
      end
    end
  end

  task automatic clear_in();
    bus.valid = 0; bus.CSRWrite = 0; bus.CSRRead = 0; bus.CSROp = 3'b000;
    bus.csr_addr = 12'h0; bus.rs1_data = 0; bus.csr_zimm = 0; bus.IsMRET = 0;
    bus.Exception = 0; bus.ExceptionCause = 0; bus.pc = 0; bus.inst_retire = 0;
  endtask

  task automatic csr_op(input logic [2:0] op, input logic [11:0] a,
                        input logic [31:0] rs1, input logic [4:0] z);
    @(posedge clk); #1;
    clear_in();
    bus.valid = 1; bus.CSRWrite = 1; bus.CSRRead = 1; bus.CSROp = op;
    bus.csr_addr = a; bus.rs1_data = rs1; bus.csr_zimm = z;
  endtask

  task automatic rd(input logic [11:0] a);
    @(posedge clk); #1;
    clear_in();
    bus.valid = 1; bus.CSRRead = 1; bus.csr_addr = a;
  endtask

  task automatic exc(input logic [31:0] pcv, input logic [31:0] cause);
    @(posedge clk); #1;
    clear_in();
    bus.valid = 1; bus.Exception = 1; bus.pc = pcv; bus.ExceptionCause = cause;
  endtask

  task automatic mret();
    @(posedge clk); #1;
    clear_in();
    bus.valid = 1; bus.IsMRET = 1;
  endtask

  logic [11:0] pool [0:10];
  logic [2:0]  ops  [0:5];

  initial begin
    clear_in();
    model_reset();
    chk_en = 1;
    repeat (3) @(posedge clk);
    #1 rstn = 1;

    rd(12'h300); @(negedge clk);
    chk("reset_mstatus", bus.rdata, 32'h0000_1800);
    chk("reset_redirect", 32'(bus.trap_redirect), 32'd0);
    chk("reset_target", bus.trap_target, 32'd0);

    csr_op(3'b001, 12'h340, 32'hDEAD_BEEF, 5'd0); @(negedge clk);
    chk("csrrw_old", bus.rdata, 32'h0);
    csr_op(3'b010, 12'h340, 32'h0000_0010, 5'd0); @(negedge clk);
    chk("csrrs_old", bus.rdata, 32'hDEAD_BEEF);
    rd(12'h340); @(negedge clk);
    chk("mscratch_rs", bus.rdata, 32'hDEAD_BEFF);
    @(posedge clk); #1;
    chk("model_mscratch", m_mscratch, 32'hDEAD_BEFF);
    clear_in();

    csr_op(3'b101, 12'h305, 32'h0, 5'h13);
    rd(12'h305); @(negedge clk);
    chk("mtvec_rwi", bus.rdata, 32'h0000_0010);

    csr_op(3'b001, 12'h305, 32'h0000_0200, 5'd0);
    csr_op(3'b110, 12'h300, 32'h0, 5'h08);
    rd(12'h300); @(negedge clk);
    chk("mstatus_mie", bus.rdata, 32'h0000_1808);

    exc(32'h0000_0104, 32'd11);
    exc(32'h0000_0500, 32'd2); @(negedge clk);
    chk("trap_pulse", 32'(bus.trap_redirect), 32'd1);
    chk("trap_tgt", bus.trap_target, 32'h0000_0200);
    rd(12'h300); @(negedge clk);
    chk("trap_pulse_end", 32'(bus.trap_redirect), 32'd0);
    chk("trap_mstatus", bus.rdata, 32'h0000_1880);
    rd(12'h341); @(negedge clk);
    chk("trap_mepc", bus.rdata, 32'h0000_0104);
    rd(12'h342); @(negedge clk);
    chk("trap_mcause", bus.rdata, 32'd11);

    mret();
    rd(12'h300); @(negedge clk);
    chk("mret_pulse", 32'(bus.trap_redirect), 32'd1);
    chk("mret_tgt", bus.trap_target, 32'h0000_0104);
    chk("mret_mstatus", bus.rdata, 32'h0000_1888);
    rd(12'h300); @(negedge clk);
    chk("mret_pulse_end", 32'(bus.trap_redirect), 32'd0);

    csr_op(3'b010, 12'h7C0, 32'hFFFF_FFFF, 5'd0); @(negedge clk);
    chk("illegal_flag", 32'(bus.illegal_csr), 32'd1);
    chk("illegal_rdata", bus.rdata, 32'h0);
    rd(12'h340); @(negedge clk);
    chk("illegal_nochange", bus.rdata, 32'hDEAD_BEFF);

    // write to mtvec immediately before a trap must be used by that trap
    csr_op(3'b001, 12'h305, 32'h0000_0300, 5'd0);
    exc(32'h0000_0208, 32'd7);
    rd(12'h300); @(negedge clk);
    chk("fwd_mtvec_tgt", bus.trap_target, 32'h0000_0300);
    chk("fwd_mtvec_pulse", 32'(bus.trap_redirect), 32'd1);

    // Exception + MRET + CSR write in one cycle: only the exception acts
    @(posedge clk); #1;
    clear_in();
    bus.valid = 1; bus.Exception = 1; bus.IsMRET = 1; bus.CSRWrite = 1;
    bus.CSROp = 3'b001; bus.csr_addr = 12'h340; bus.rs1_data = 32'h0;
    bus.pc = 32'h0000_0400; bus.ExceptionCause = 32'd3;
    rd(12'h340); @(negedge clk);
    chk("prio_tgt", bus.trap_target, 32'h0000_0300);
    chk("prio_mscratch", bus.rdata, 32'hDEAD_BEFF);
    rd(12'h300); @(negedge clk);
    chk("prio_mstatus", bus.rdata, 32'h0000_1800);

`ifdef CSR_COUNTERS_EN
    csr_op(3'b001, 12'hB00, 32'hFFFF_FFFF, 5'd0);
    rd(12'hB00); @(negedge clk);
    chk("mcycle_written", bus.rdata, 32'hFFFF_FFFF);
    rd(12'hB00); @(negedge clk);
    chk("mcycle_wrap", bus.rdata, 32'h0);
    rd(12'hB80); @(negedge clk);
    chk("mcycleh_carry", bus.rdata, 32'h1);
`else
    rd(12'hB00); @(negedge clk);
    chk("mcycle_absent", 32'(bus.illegal_csr), 32'd1);
`endif

    // asynchronous reset in the middle of a redirect pulse
    exc(32'h0000_0040, 32'd3);
    @(posedge clk); #1 clear_in();
    #2 rstn = 0;
    @(negedge clk);
    chk("rst_kills_pulse", 32'(bus.trap_redirect), 32'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    repeat (2) @(negedge clk);
    chk("no_pulse_after_rst", 32'(bus.trap_redirect), 32'd0);

    pool[0] = 12'h300; pool[1] = 12'h305; pool[2] = 12'h340; pool[3] = 12'h341;
    pool[4] = 12'h342; pool[5] = 12'hB00; pool[6] = 12'hB80; pool[7] = 12'hB02;
    pool[8] = 12'hB82; pool[9] = 12'h7C0; pool[10] = 12'h301;
    ops[0] = 3'b001; ops[1] = 3'b010; ops[2] = 3'b011;
    ops[3] = 3'b101; ops[4] = 3'b110; ops[5] = 3'b111;

    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      bus.valid          = ($urandom_range(0, 9) != 0);
      bus.CSRWrite       = $urandom_range(0, 1);
      bus.CSRRead        = $urandom_range(0, 1);
      bus.CSROp          = ops[$urandom_range(0, 5)];
      bus.csr_addr       = ($urandom_range(0, 15) == 0) ? 12'($urandom) : pool[$urandom_range(0, 10)];
      bus.rs1_data       = $urandom;
      bus.csr_zimm       = 5'($urandom);
      bus.Exception      = ($urandom_range(0, 11) == 0);
      bus.IsMRET         = ($urandom_range(0, 9) == 0);
      bus.ExceptionCause = $urandom;
      bus.pc             = $urandom;
      bus.inst_retire    = $urandom_range(0, 1);
    end

    @(posedge clk); #1 clear_in();
    @(negedge clk);
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/csr_unit.md
# csr_unit

Machine-mode CSR file and trap sequencer executing the CSR, ECALL and MRET controls produced by the instruction decoder. It holds the machine CSRs and performs CSRRW/RS/RC and their immediate forms. On a trap or return it updates trap state and emits a one-cycle registered PC redirect to the fetch stage. It sits in the EX/MEM boundary beside the ALU and returns old CSR values to the writeback mux (WDSel = 11).

## Interface
- `RESET_MTVEC`, default 32'h0000_0000: reset value of mtvec, forced word-aligned.
- `clk` input 1: the single clock.
- `rstn` input 1: asynchronous, active-low reset.
- `valid` input 1: the instruction presented this cycle is live and not squashed.
- `CSRWrite`, `CSRRead` input 1 each: CSR write/read enables from the decoder.
- `CSROp` input 3: funct3; 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- `csr_addr` input 12: CSR address.
- `rs1_data` input 32: forwarded rs1 value.
- `csr_zimm` input 5: rs1 field used as the immediate.
- `IsMRET`, `Exception` input 1 each: decoder indicators.
- `ExceptionCause` input 32: trap cause.
- `pc` input 32: PC of the instruction presented.
- `inst_retire` input 1: one instruction retired this cycle.
- `rdata` output 32: old value of the addressed CSR (combinational).
- `illegal_csr` output 1: the address is unimplemented and CSRRead or CSRWrite is set (combinational).
- `trap_redirect` output 1: registered one-cycle flush and redirect pulse.
- `trap_target` output 32: registered redirect PC, valid while `trap_redirect` is 1.

## Operation
- Implemented CSRs:
  - mstatus 0x300: MIE is bit 3, MPIE is bit 7, MPP is bits 12:11 hardwired to 11. All other bits read 0 and ignore writes.
  - mtvec 0x305: direct mode only, bits 1:0 read 0.
  - mscratch 0x340.
  - mepc 0x341: bits 1:0 read 0.
  - mcause 0x342.
- CSR operand: `{27'b0, csr_zimm}` when `CSROp[2]` is 1, otherwise `rs1_data`.
- New CSR value:
  - RW forms: the operand.
  - RS forms: old OR operand.
  - RC forms: old AND NOT operand.
  - The value is written at the clock edge only when `valid & CSRWrite & ~illegal_csr` in state IDLE.
- `rdata` is the pre-write value. It is 0 when the address is unimplemented.
- State machine has two states, IDLE and REDIRECT.
  - IDLE, with `valid & Exception`:
    - mepc <= pc, mcause <= ExceptionCause.
    - MPIE <= MIE, MIE <= 0.
    - trap_target <= mtvec.
    - Go to REDIRECT.
  - IDLE, with `valid & IsMRET`:
    - MIE <= MPIE, MPIE <= 1.
    - trap_target <= mepc.
    - Go to REDIRECT.
  - REDIRECT lasts exactly one cycle with `trap_redirect` = 1. All inputs except `inst_retire` are ignored, because the pipeline is being flushed. It then returns to IDLE.
- Priority within one cycle: Exception > IsMRET > CSR write. A lower-priority action is dropped when a higher one fires.
- Writes to mtvec or mepc in the cycle before a trap or return are visible to that trap or return: the edge-N write precedes the edge-N+1 capture.

## Timing
- Reset values:
  - mstatus = 32'h0000_1800, mtvec = RESET_MTVEC & ~3.
  - mscratch = mepc = mcause = 0.
  - State is IDLE; trap_redirect = 0, trap_target = 0.
  - Counters, when compiled in, are 0.
- `rdata` and `illegal_csr` have zero latency, combinational from the inputs.
- CSR write takes effect at the edge ending the cycle and is readable the next cycle.
- Exception or MRET presented in cycle N gives `trap_redirect` high in cycle N+1 only. A second Exception in N+1 is ignored.
- Reset asserted mid-REDIRECT clears the pulse immediately (asynchronous); no redirect is issued after release.

## Configuration
- `CSR_COUNTERS_EN` defined adds 64-bit mcycle (0xB00 low / 0xB80 high) and minstret (0xB02 low / 0xB82 high).
  - mcycle increments every cycle.
  - minstret increments when `inst_retire` is 1.
  - A CSR write to either half wins over that cycle's increment. Carry out of the low half propagates to the high half on the same edge.
- Undefined: those addresses are unimplemented and raise `illegal_csr`.

## Test plan
- CSRRW mscratch, rs1_data = 32'hDEAD_BEEF, then CSRRS mscratch, rs1_data = 32'h0000_0010 → rdata 0 on the first, 32'hDEAD_BEEF on the second; mscratch ends at 32'hDEAD_BEFF.
- CSRRWI mtvec, zimm = 5'h13 → mtvec reads 32'h0000_0010; bits 1:0 are forced 0.
- mstatus MIE = 1, ECALL at pc = 32'h0000_0104, mtvec = 32'h0000_0200 → next cycle trap_redirect = 1 and trap_target = 32'h200; mepc = 32'h104; mcause = 11; mstatus = 32'h0000_1880.
- MRET after that trap → trap_redirect pulses one cycle with target 32'h104; mstatus returns to 32'h0000_1888.
- CSRRS with CSRRead = 1 at address 0x7C0 → illegal_csr = 1, rdata = 0, no state change.
- With `CSR_COUNTERS_EN`, write mcycle low = 32'hFFFF_FFFF → one cycle later mcycleh = 1 and mcycle = 0.
